// File: rtl/os_scheduler.sv
// Round-robin process scheduler for a single-issue CPU.
// Boots through BIOS, then time-slices the loaded programs. Each switch
// copies the register file to or from context memory, one register per
// cycle. A process that executes HALT is retired and is never scheduled again.
module os_scheduler #(
   parameter int          NPROC     = 4,
   parameter int          QUANTUM   = 1000,
   parameter logic [31:0] PC_BASE   = 32'h0000_1000,
   parameter logic [31:0] PC_STRIDE = 32'h0000_1000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             halt,
   input  logic [NPROC-1:0] proc_valid,
   input  logic [31:0]      pc_in,
   output logic             sel_bios,
   output logic             cpu_stall,
   output logic [1:0]       cur_pid,
   output logic             ctx_save,
   output logic             ctx_restore,
   output logic [4:0]       ctx_reg_idx,
   output logic             pc_load,
   output logic [31:0]      pc_out,
   output logic             all_done
);

   localparam int CW = (QUANTUM > 2) ? $clog2(QUANTUM) : 1;

   typedef enum logic [2:0] {
      S_BIOS    = 3'd0,
      S_SELECT  = 3'd1,
      S_RESTORE = 3'd2,
      S_RUN     = 3'd3,
      S_SAVE    = 3'd4,
      S_IDLE    = 3'd5
   } state_t;

   state_t          state, state_nxt;
   logic [4:0]      idx;
   logic [CW-1:0]   counter;
   logic [NPROC-1:0] done;
   logic [31:0]     pc_table [NPROC];

   logic            sel_found;
   logic [1:0]      sel_pid;
   logic            last_reg;
   logic            expire;

   assign last_reg = (idx == 5'd31);
   assign expire   = (counter == CW'(QUANTUM - 1));

   // Round-robin pick: scan from cur_pid+1 around to cur_pid itself. The
   // loop runs farthest-first so the nearest runnable candidate wins.
   always_comb begin
      logic [1:0] cand;
      sel_found = 1'b0;
      sel_pid   = cur_pid;
      cand      = '0;
      for (int k = NPROC; k >= 1; k--) begin
         cand = 2'((32'(cur_pid) + k) % NPROC);
         if (proc_valid[cand] && !done[cand]) begin
            sel_found = 1'b1;
            sel_pid   = cand;
         end
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_BIOS;
      else       state <= state_nxt;
   end

   // Next-state logic. In RUN, halt takes priority over quantum expiry.
   always_comb begin
      state_nxt = state;
      case (state)
         S_BIOS:    if (halt) state_nxt = S_SELECT;
         S_SELECT:  state_nxt = sel_found ? S_RESTORE : S_IDLE;
         S_RESTORE: if (last_reg) state_nxt = S_RUN;
         S_RUN: begin
            if (halt)        state_nxt = S_SELECT;
            else if (expire) state_nxt = S_SAVE;
         end
         S_SAVE:    if (last_reg) state_nxt = S_SELECT;
         S_IDLE:    state_nxt = S_IDLE;
         default:   state_nxt = S_BIOS;
      endcase
   end

   // Scheduler datapath: owner pid, copy index, slice counter, retire flags
   // and saved PCs. Reset aborts any copy in flight and reloads the PC table.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_pid <= 2'(NPROC - 1);
         idx     <= '0;
         counter <= '0;
         done    <= '0;
         for (int i = 0; i < NPROC; i++)
            pc_table[i] <= PC_BASE + 32'(i) * PC_STRIDE;
      end else begin
         case (state)
            S_SELECT: begin
               idx <= '0;
               if (sel_found) cur_pid <= sel_pid;
            end
            S_RESTORE: begin
               idx <= idx + 5'd1;
               if (last_reg) counter <= '0;
            end
            S_RUN: begin
               idx     <= '0;
               counter <= counter + 1'b1;
               if (halt)        done[cur_pid]     <= 1'b1;
               else if (expire) pc_table[cur_pid] <= pc_in;
            end
            S_SAVE:  idx <= idx + 5'd1;
            default: idx <= '0;
         endcase
      end
   end

   // Moore output decode from the registered state.
   always_comb begin
      sel_bios    = 1'b0;
      cpu_stall   = 1'b1;
      ctx_save    = 1'b0;
      ctx_restore = 1'b0;
      ctx_reg_idx = '0;
      pc_load     = 1'b0;
      pc_out      = '0;
      all_done    = 1'b0;
      case (state)
         S_BIOS: begin
            sel_bios  = 1'b1;
            cpu_stall = 1'b0;
         end
         S_RESTORE: begin
            ctx_restore = 1'b1;
            ctx_reg_idx = idx;
            if (last_reg) begin
               pc_load = 1'b1;
               pc_out  = pc_table[cur_pid];
            end
         end
         S_RUN:   cpu_stall = 1'b0;
         S_SAVE: begin
            ctx_save    = 1'b1;
            ctx_reg_idx = idx;
         end
         S_IDLE:  all_done = 1'b1;
         default: cpu_stall = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_os_scheduler.sv
// Randomized scoreboard bench for os_scheduler. The driver issues boot/halt/
// expiry events and pushes the expected dispatch into a queue using a
// process-table model; the monitor pops on every pc_load or all_done rise.
module tb_os_scheduler;
   localparam int          Q   = 8;
   localparam logic [31:0] PCB = 32'h0000_1000;
   localparam logic [31:0] PCS = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        halt = 1'b0;
   logic [3:0]  proc_valid = 4'b0;
   logic [31:0] pc_in = 32'b0;
   logic        sel_bios, cpu_stall, ctx_save, ctx_restore, pc_load, all_done;
   logic [1:0]  cur_pid;
   logic [4:0]  ctx_reg_idx;
   logic [31:0] pc_out;

   os_scheduler #(.NPROC(4), .QUANTUM(Q), .PC_BASE(PCB), .PC_STRIDE(PCS)) dut (
      .clk(clk), .reset(reset), .halt(halt), .proc_valid(proc_valid),
      .pc_in(pc_in), .sel_bios(sel_bios), .cpu_stall(cpu_stall),
      .cur_pid(cur_pid), .ctx_save(ctx_save), .ctx_restore(ctx_restore),
      .ctx_reg_idx(ctx_reg_idx), .pc_load(pc_load), .pc_out(pc_out),
      .all_done(all_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          idle;
      int          pid;
      logic [31:0] pc;
      int          lat;
      int          nsave;
      int          mark;
   } rec_t;

   rec_t q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   bit   abort_all = 1'b0;

   // Process-table model
   logic [31:0] m_pc [4];
   bit          m_done [4];
   logic [3:0]  m_valid;
   int          m_cur;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic void m_init(input logic [3:0] mask);
      for (int i = 0; i < 4; i++) begin
         m_pc[i]   = PCB + 32'(i) * PCS;
         m_done[i] = 1'b0;
      end
      m_valid = mask;
      m_cur   = 3;
   endfunction

   function automatic int m_pick();
      for (int k = 1; k <= 4; k++) begin
         int p;
         p = (m_cur + k) % 4;
         if (m_valid[p] && !m_done[p]) return p;
      end
      return -1;
   endfunction

   // lat_sel: cycles from the triggering edge until the SELECT cycle.
   task automatic m_dispatch(input int lat_sel, input int nsave, input int mk);
      rec_t r;
      int   p;
      p       = m_pick();
      r.idle  = (p < 0);
      r.pid   = (p < 0) ? 0 : p;
      r.pc    = (p < 0) ? 32'h0 : m_pc[p];
      r.lat   = (p < 0) ? lat_sel + 1 : lat_sel + 32;
      r.nsave = nsave;
      r.mark  = mk;
      if (p >= 0) m_cur = p;
      q.push_back(r);
   endtask

   // Monitor: copy-index sequencing every cycle, scoreboard pop on events.
   initial begin : monitor
      int   nres, nsav;
      bit   was_done;
      rec_t r;
      nres = 0; nsav = 0; was_done = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            nres = 0; nsav = 0; was_done = 1'b0;
         end else begin
            chk("save_restore_excl", 32'(ctx_save & ctx_restore), 32'h0);
            if (ctx_restore) begin
               chk("restore_idx", 32'(ctx_reg_idx), 32'(nres));
               nres++;
            end else if (ctx_save) begin
               chk("save_idx", 32'(ctx_reg_idx), 32'(nsav));
               nsav++;
            end else begin
               chk("idx_zero", 32'(ctx_reg_idx), 32'h0);
               chk("pc_load_zero", 32'(pc_load), 32'h0);
            end
            if (pc_load) begin
               if (q.size() == 0) begin
                  n_chk++; n_fail++;
                  $display("FAIL unexpected_pc_load: got pid %0d pc %h expected none", cur_pid, pc_out);
               end else begin
                  r = q.pop_front();
                  chk("dispatch_kind", 32'(r.idle), 32'h0);
                  chk("dispatch_pid", 32'(cur_pid), 32'(r.pid));
                  chk("dispatch_pc", pc_out, r.pc);
                  chk("dispatch_lat", 32'(cyc - r.mark), 32'(r.lat));
                  chk("restore_count", 32'(nres), 32'd32);
                  chk("save_count", 32'(nsav), 32'(r.nsave));
                  chk("restore_stall", 32'(cpu_stall), 32'h1);
               end
               nres = 0; nsav = 0;
            end
            if (all_done && !was_done) begin
               if (q.size() == 0) begin
                  n_chk++; n_fail++;
                  $display("FAIL unexpected_all_done: got 1 expected 0");
               end else begin
                  r = q.pop_front();
                  chk("idle_kind", 32'(r.idle), 32'h1);
                  chk("idle_lat", 32'(cyc - r.mark), 32'(r.lat));
                  chk("idle_save_count", 32'(nsav), 32'(r.nsave));
                  chk("idle_restore_count", 32'(nres), 32'h0);
                  chk("idle_stall", 32'(cpu_stall), 32'h1);
               end
            end
            was_done = all_done;
         end
      end
   end

   task automatic apply_reset(input logic [3:0] mask);
      @(negedge clk);
      reset = 1'b1; halt = 1'b0; proc_valid = mask;
      q.delete();
      m_init(mask);
      repeat (2) @(negedge clk);
      chk("rst_sel_bios", 32'(sel_bios), 32'h1);
      chk("rst_cpu_stall", 32'(cpu_stall), 32'h0);
      chk("rst_cur_pid", 32'(cur_pid), 32'h3);
      chk("rst_ctx_save", 32'(ctx_save), 32'h0);
      chk("rst_ctx_restore", 32'(ctx_restore), 32'h0);
      chk("rst_idx", 32'(ctx_reg_idx), 32'h0);
      chk("rst_pc_load", 32'(pc_load), 32'h0);
      chk("rst_pc_out", pc_out, 32'h0);
      chk("rst_all_done", 32'(all_done), 32'h0);
      reset = 1'b0;
   endtask

   task automatic boot();
      int mk;
      repeat (2) @(negedge clk);
      chk("bios_sel", 32'(sel_bios), 32'h1);
      chk("bios_stall", 32'(cpu_stall), 32'h0);
      halt = 1'b1; mk = cyc;
      @(negedge clk);
      halt = 1'b0;
      chk("select_stall", 32'(cpu_stall), 32'h1);
      chk("select_bios", 32'(sel_bios), 32'h0);
      m_dispatch(1, 0, mk);
   endtask

   task automatic wait_event(output bit idle);
      int n;
      n = 0; idle = 1'b0;
      while (1) begin
         @(negedge clk);
         if (pc_load) return;
         if (all_done) begin idle = 1'b1; return; end
         if (++n > 200) begin
            n_chk++; n_fail++;
            $display("FAIL wait_event: got no pc_load/all_done in 200 cycles, expected one");
            abort_all = 1'b1;
            return;
         end
      end
   endtask

   // mode 0: random, 1: halt on the last quantum cycle, 2: expire with fpc
   task automatic run_slice(input int mode, input logic [31:0] fpc, input bit abort,
                            output bit aborted);
      bit          dh;
      int          h, mk, n;
      logic [31:0] npc;
      aborted = 1'b0;
      case (mode)
         1:       begin dh = 1'b1; h = Q - 1; end
         2:       begin dh = 1'b0; h = Q - 1; end
         default: begin
            dh = ($urandom_range(0, 1) == 1);
            h  = !dh ? Q - 1 : (($urandom_range(0, 1) == 1) ? Q - 1 : int'($urandom_range(0, Q - 2)));
         end
      endcase
      npc = (mode == 2) ? fpc : ($urandom & 32'hFFFF_FFFC);
      mk  = 0;
      for (int c = 0; c <= h; c++) begin
         @(negedge clk);
         chk("run_stall", 32'(cpu_stall), 32'h0);
         chk("run_bios", 32'(sel_bios), 32'h0);
         pc_in = (c == h) ? npc : $urandom;
         halt  = dh && (c == h);
         mk    = cyc;
      end
      @(negedge clk);
      halt = 1'b0;
      chk("post_slice_stall", 32'(cpu_stall), 32'h1);
      if (dh) begin
         m_done[m_cur] = 1'b1;
         m_dispatch(1, 0, mk);
      end else if (abort) begin
         n = 0;
         while (!(ctx_save && ctx_reg_idx == 5'd17)) begin
            @(negedge clk);
            if (++n > 64) begin
               n_chk++; n_fail++;
               $display("FAIL wait_idx17: got no save idx 17 in 64 cycles, expected one");
               abort_all = 1'b1;
               return;
            end
         end
         reset = 1'b1;
         #1;
         chk("abort_sel_bios", 32'(sel_bios), 32'h1);
         chk("abort_ctx_save", 32'(ctx_save), 32'h0);
         chk("abort_idx", 32'(ctx_reg_idx), 32'h0);
         chk("abort_cur_pid", 32'(cur_pid), 32'h3);
         chk("abort_stall", 32'(cpu_stall), 32'h0);
         aborted = 1'b1;
      end else begin
         m_pc[m_cur] = npc;
         m_dispatch(33, 32, mk);
      end
   endtask

   task automatic scenario(input logic [3:0] mask, input bit abort, input bit first_fixed);
      bit idle, ab;
      int ns, mode;
      apply_reset(mask);
      boot();
      ns = 0;
      while (!abort_all) begin
         wait_event(idle);
         if (abort_all) break;
         if (idle) begin
            repeat (4) @(negedge clk);
            chk("idle_held_done", 32'(all_done), 32'h1);
            chk("idle_held_stall", 32'(cpu_stall), 32'h1);
            break;
         end
         mode = 0;
         if ((first_fixed || abort) && ns == 0) mode = 2;
         else if (ns >= 24) mode = 1;
         run_slice(mode, first_fixed ? 32'h0000_1010 : $urandom, abort && ns == 0, ab);
         ns++;
         if (ab) begin
            apply_reset(mask);
            boot();
         end
      end
   endtask

   initial begin
      scenario(4'b0101, 1'b0, 1'b1);
      scenario(4'b1000, 1'b0, 1'b0);
      scenario(4'b1000, 1'b1, 1'b0);
      scenario(4'b0000, 1'b0, 1'b0);
      for (int s = 0; s < 5 && !abort_all; s++)
         scenario(4'($urandom_range(1, 15)), 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      chk("queue_drained", 32'(q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
